// File: rtl/nway_rr_cache.sv
// N-way set-associative write-back byte cache with valid-first / LFSR-random replacement
// and a line-wide request/ready memory port.
module nway_rr_cache #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned SET_BITS  = 7,
  parameter int unsigned OFF_BITS  = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic                       rw,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata,
  output logic                       rdy,
  output logic                       busy,
  output logic                       mem_req,
  output logic                       mem_rw,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [(8<<OFF_BITS)-1:0]   mem_wdata,
  input  logic [(8<<OFF_BITS)-1:0]   mem_rdata,
  input  logic                       mem_rdy,
  output logic [15:0]                hit_cnt,
  output logic [15:0]                miss_cnt
);

  localparam int unsigned TAG_W = ADDR_W - SET_BITS - OFF_BITS;
  localparam int unsigned LW    = 8 << OFF_BITS;
  localparam int unsigned SETS  = 1 << SET_BITS;
  localparam int unsigned WB    = $clog2(WAYS);

  typedef enum logic [1:0] {StIdle, StLookup, StWback, StFill} state_e;

  logic             valid_q [WAYS][SETS];
  logic             dirty_q [WAYS][SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [LW-1:0]    data_q  [WAYS][SETS];

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             rdy_q, rdy_d, busy_q, busy_d, first_q, first_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [15:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [WB-1:0]    victim_q, victim_d;

  logic [TAG_W-1:0]    tag_in;
  logic [SET_BITS-1:0] set_in;
  logic [OFF_BITS+2:0] bit_idx;
  logic                hit, inv_found, fill_we, byte_we;
  logic [WB-1:0]       hit_way, inv_way, victim_way;
  logic [LW-1:0]       hit_line;
  logic [ADDR_W-1:0]   fill_addr;

  assign tag_in    = addr[ADDR_W-1 -: TAG_W];
  assign set_in    = addr[OFF_BITS +: SET_BITS];
  assign bit_idx   = {addr[OFF_BITS-1:0], 3'b000};
  assign fill_addr = {tag_in, set_in, {OFF_BITS{1'b0}}};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][set_in] && (tag_q[w][set_in] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[w][set_in] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
    victim_way = inv_found ? inv_way : lfsr_q[WB-1:0];
    hit_line   = data_q[hit_way][set_in];
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    rdy_d       = 1'b0;
    first_d     = first_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    victim_d    = victim_q;
    fill_we     = 1'b0;
    byte_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLookup;
          lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          first_d = 1'b1;
        end
      end
      StLookup: begin
        first_d = 1'b0;
        if (hit) begin
          if (first_q) hit_cnt_d = sat_inc(hit_cnt_q);
          if (rw) byte_we = 1'b1;
          else    rdata_d = hit_line[bit_idx +: 8];
          rdy_d   = 1'b1;
          state_d = StIdle;
        end else begin
          if (first_q) miss_cnt_d = sat_inc(miss_cnt_q);
          victim_d  = victim_way;
          mem_req_d = 1'b1;
          if (valid_q[victim_way][set_in] && dirty_q[victim_way][set_in]) begin
            mem_rw_d    = 1'b1;
            mem_addr_d  = {tag_q[victim_way][set_in], set_in, {OFF_BITS{1'b0}}};
            mem_wdata_d = data_q[victim_way][set_in];
            state_d     = StWback;
          end else begin
            mem_rw_d   = 1'b0;
            mem_addr_d = fill_addr;
            state_d    = StFill;
          end
        end
      end
      StWback: begin
        // Drop the request for one cycle; the fill is raised from StFill.
        if (mem_rdy) begin
          mem_req_d = 1'b0;
          state_d   = StFill;
        end
      end
      StFill: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_rw_d   = 1'b0;
          mem_addr_d = fill_addr;
        end else if (mem_rdy) begin
          mem_req_d = 1'b0;
          fill_we   = 1'b1;
          state_d   = StLookup;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEED;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      first_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      victim_q    <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      first_q     <= first_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      victim_q    <= victim_d;
      if (fill_we) begin
        valid_q[victim_q][set_in] <= 1'b1;
        dirty_q[victim_q][set_in] <= 1'b0;
        tag_q[victim_q][set_in]   <= tag_in;
        data_q[victim_q][set_in]  <= mem_rdata;
      end
      if (byte_we) begin
        data_q[hit_way][set_in][bit_idx +: 8] <= wdata;
        dirty_q[hit_way][set_in]              <= 1'b1;
      end
    end
  end

  assign rdata     = rdata_q;
  assign rdy       = rdy_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_nway_rr_cache.sv
// Bench for nway_rr_cache: random byte traffic against a set/way reference model, with a
// scoreboard for CPU completions and a checking memory responder for line transfers.
module tb_nway_rr_cache;

  localparam int ADDR_W = 16, WAYS = 2, SET_BITS = 7, OFF_BITS = 2;
  localparam int LW = 8 << OFF_BITS, SETS = 1 << SET_BITS;

  logic          clk, rst_n, req, rw, rdy, busy, mem_req, mem_rw, mem_rdy;
  logic [15:0]   addr, mem_addr, hit_cnt, miss_cnt;
  logic [7:0]    wdata, rdata;
  logic [LW-1:0] mem_wdata, mem_rdata;

  nway_rr_cache #(
    .ADDR_W(ADDR_W), .WAYS(WAYS), .SET_BITS(SET_BITS), .OFF_BITS(OFF_BITS), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdy(rdy), .busy(busy), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit is_read; logic [7:0] rdata; int hits; int misses; } exp_t;
  typedef struct { bit rw; logic [15:0] addr; logic [LW-1:0] wdata; } mop_t;
  exp_t exp_q[$];
  mop_t mop_q[$];

  int n_checks = 0, n_errors = 0;
  bit mem_hold = 1'b0;

  // Reference model: per-set way contents, main memory, LFSR value, counters.
  bit            m_valid [WAYS][SETS];
  bit            m_dirty [WAYS][SETS];
  int            m_tag   [WAYS][SETS];
  logic [LW-1:0] m_line  [WAYS][SETS];
  logic [LW-1:0] dram [int];
  logic [7:0]    m_lfsr;
  int            m_hits, m_misses;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] dram_rd(input int la);
    if (dram.exists(la)) return dram[la];
    return (LW'(la) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    m_lfsr   = 8'hA5;
    m_hits   = 0;
    m_misses = 0;
    exp_q.delete();
    mop_q.delete();
  endtask

  task automatic model_access(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                              output bit was_hit);
    int tg, st, of, way;
    exp_t e;
    mop_t m;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    tg  = int'(a) / (1 << (SET_BITS + OFF_BITS));
    st  = (int'(a) / (1 << OFF_BITS)) % SETS;
    of  = int'(a) % (1 << OFF_BITS);
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][st] && m_tag[w][st] == tg) way = w;
    was_hit = (way >= 0);
    if (was_hit) m_hits = sat(m_hits);
    else begin
      m_misses = sat(m_misses);
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[w][st]) way = w;
      if (way < 0) way = int'(m_lfsr) % WAYS;
      if (m_valid[way][st] && m_dirty[way][st]) begin
        m.rw    = 1'b1;
        m.addr  = 16'((m_tag[way][st] * SETS + st) * (1 << OFF_BITS));
        m.wdata = m_line[way][st];
        mop_q.push_back(m);
        dram[int'(m.addr) / (1 << OFF_BITS)] = m_line[way][st];
      end
      m.rw    = 1'b0;
      m.addr  = 16'((tg * SETS + st) * (1 << OFF_BITS));
      m.wdata = '0;
      mop_q.push_back(m);
      m_line[way][st]  = dram_rd(int'(m.addr) / (1 << OFF_BITS));
      m_valid[way][st] = 1'b1;
      m_dirty[way][st] = 1'b0;
      m_tag[way][st]   = tg;
    end
    if (wr) begin
      m_line[way][st][of*8 +: 8] = wd;
      m_dirty[way][st] = 1'b1;
    end
    e.is_read = !wr;
    e.rdata   = m_line[way][st][of*8 +: 8];
    e.hits    = m_hits;
    e.misses  = m_misses;
    exp_q.push_back(e);
  endtask

  // Monitor: every rdy pulse is matched against the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_rdy", 64'(rdy), 64'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_read) check("rdata", 64'(rdata), 64'(e.rdata));
        check("hit_cnt", 64'(hit_cnt), 64'(e.hits));
        check("miss_cnt", 64'(miss_cnt), 64'(e.misses));
      end
    end
  end

  // Memory responder: random 0..3 extra wait cycles, checks each transfer.
  int delay = -1;
  always @(negedge clk) begin
    if (mem_rdy) mem_rdy = 1'b0;
    else if (rst_n === 1'b1 && mem_req === 1'b1 && !mem_hold) begin
      if (delay < 0) delay = int'($urandom_range(0, 3));
      if (delay == 0) begin
        delay = -1;
        if (mop_q.size() == 0) check("unexpected_mem_req", 64'(mem_req), 64'd0);
        else begin
          mop_t m;
          m = mop_q.pop_front();
          check("mem_rw", 64'(mem_rw), 64'(m.rw));
          check("mem_addr", 64'(mem_addr), 64'(m.addr));
          if (m.rw) check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
        end
        mem_rdata = mem_rw ? '0 : dram_rd(int'(mem_addr) / (1 << OFF_BITS));
        mem_rdy   = 1'b1;
      end else delay--;
    end else delay = -1;
  end

  task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] wd);
    bit h;
    int cyc;
    model_access(wr, a, wd, h);
    @(negedge clk);
    req = 1'b1; rw = wr; addr = a; wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rdy !== 1'b1 && cyc < 200);
    if (rdy !== 1'b1) check("rdy_timeout", 64'(rdy), 64'd1);
    else if (h) check("hit_latency", 64'(cyc), 64'd2);
    req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outputs", {rdy, busy, mem_req, mem_rw}, 64'd0);
    check("rst_data", {rdata, mem_addr, mem_wdata}, 64'd0);
    check("rst_counters", {hit_cnt, miss_cnt}, 64'd0);
    rst_n = 1'b1;

    access(1'b0, 16'h0000, 8'h00);
    access(1'b1, 16'h1203, 8'h5A);
    access(1'b0, 16'h1203, 8'h00);
    // Set 0: tags 1 (dirty) and 2 force an LFSR-chosen eviction.
    access(1'b1, 16'h0201, 8'hC3);
    access(1'b0, 16'h0402, 8'h00);
    access(1'b0, 16'h0001, 8'h00);
    // Set 5 filled from empty, then a third tag.
    for (int t = 0; t < 3; t++) access(1'b1, 16'((t << 9) | (5 << 2) | t), 8'(8'h30 + t));

    // Reset while a fill is outstanding.
    mem_hold = 1'b1;
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 16'h0990;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (mem_req !== 1'b1 && cyc < 20);
    check("hold_fill_addr", 64'(mem_addr), 64'h0990);
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_req", 64'(mem_req), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    rst_n = 1'b1; mem_hold = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    access(1'b0, 16'h0990, 8'h00);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      a = 16'(($urandom_range(0, 5) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    // Counter saturation from one below the limit.
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFE;
    force dut.miss_cnt_q = 16'hFFFE;
    #1;
    release dut.hit_cnt_q;
    release dut.miss_cnt_q;
    m_hits = 65534; m_misses = 65534;
    access(1'b0, 16'h7E00, 8'h00);
    access(1'b0, 16'h7C00, 8'h00);
    access(1'b0, 16'h7A00, 8'h00);
    access(1'b0, 16'h7A00, 8'h00);
    access(1'b0, 16'h7A01, 8'h00);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("mop_q_drained", 64'(mop_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nway_rr_cache.md
# nway_rr_cache

Parametrised N-way set-associative, write-back, write-allocate byte cache with valid-first / LFSR-random replacement, sitting between a byte-wide CPU request port and a line-wide memory port. Successor to the fixed 2-way, 128-set cache. Adds:

- Configurable ways, sets and line size.
- Synchronous reset that invalidates every line.
- An external memory handshake instead of an embedded memory.
- Saturating hit/miss counters.

## Interface
- ADDR_W, 16, CPU byte-address width.
- WAYS, 2, associativity; power of 2, 2..8.
- SET_BITS, 7, log2(number of sets).
- OFF_BITS, 2, log2(bytes per line); line width LW = 8<<OFF_BITS.
- TAG_W, ADDR_W-SET_BITS-OFF_BITS, tag width (derived, not overridden).
- LFSR_SEED, 8'hA5, non-zero reset value of the replacement LFSR.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  1  CPU request; held with addr/rw/wdata until rdy.
- rw  in  1  1 = write byte, 0 = read byte.
- addr  in  ADDR_W  byte address: tag = [ADDR_W-1 : SET_BITS+OFF_BITS], set = [SET_BITS+OFF_BITS-1 : OFF_BITS], offset = [OFF_BITS-1:0].
- wdata  in  8  write byte.
- rdata  out  8  read byte; valid in the rdy cycle.
- rdy  out  1  one-cycle completion pulse.
- busy  out  1  high in every state other than IDLE.
- mem_req  out  1  memory request; level, held until mem_rdy.
- mem_rw  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  ADDR_W  line-aligned address (offset bits 0).
- mem_wdata  out  LW  write-back line.
- mem_rdata  in  LW  fill line; valid when mem_rdy = 1.
- mem_rdy  in  1  one-cycle memory completion pulse.
- hit_cnt  out  16  saturating hit count.
- miss_cnt  out  16  saturating miss count.

## Operation
- Storage per way per set: valid, dirty, tag, LW-bit data line.
- Byte k of a line occupies data bits [8k+7:8k].
- States:
  - IDLE: on req = 1, go to LOOKUP and advance the LFSR one step.
  - LOOKUP: compare all ways.
    - Hit: write the byte and set dirty (rw = 1), or drive rdata (rw = 0); pulse rdy; go to IDLE.
    - Miss with a dirty victim: latch the victim, drive the write-back, go to WBACK.
    - Miss with a clean or invalid victim: drive the fill, go to FILL.
  - WBACK: hold the request. On mem_rdy, switch to the fill request in the next cycle and go to FILL.
  - FILL: hold the request. On mem_rdy, write mem_rdata into the victim way with valid = 1, dirty = 0, tag = addr tag; go back to LOOKUP, which then hits.
- Victim selection, evaluated in the LOOKUP cycle of a miss and registered:
  - If any way in the set is invalid, use the lowest-index invalid way.
  - Otherwise use lfsr[log2(WAYS)-1:0].
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left with the feedback bit entering bit 0.
- Counters: hit_cnt +1 on each first-LOOKUP hit; miss_cnt +1 on each first-LOOKUP miss. The re-LOOKUP after a fill counts as neither. Both saturate at 16'hFFFF.
- The write-back address is {victim tag, set, OFF_BITS'b0}.
- The fill address is {addr tag, set, OFF_BITS'b0}.
- A multiple-way tag match cannot occur; behaviour for it is undefined.

## Timing
- Reset values, applied in the cycle rst_n is sampled low, regardless of current state:
  - state = IDLE.
  - rdy, busy, mem_req, mem_rw = 0.
  - rdata, mem_addr, mem_wdata = 0.
  - hit_cnt, miss_cnt = 0.
  - lfsr = LFSR_SEED.
  - All valid and dirty bits = 0; data and tags are don't-care.
- Reset mid-operation abandons the transaction. mem_req is low in the cycle after the sampling edge, and no rdy is issued.
- Hit latency: req sampled at edge 0, LOOKUP at edge 1, rdy = 1 at edge 2. rdata and the written byte are visible from edge 2.
- Clean-miss latency: 2 + Tm + 1 cycles, where Tm is the count of cycles from mem_req rising to mem_rdy inclusive.
- Dirty-miss latency: adds the write-back Tm plus 1 cycle.
- mem_req, mem_rw, mem_addr and mem_wdata are registered and stable while mem_req = 1. mem_req drops in the cycle after mem_rdy.
- rdy is high for exactly one cycle. req may remain high in that cycle; IDLE re-samples req at the following edge, so back-to-back requests are accepted with a one-cycle gap.
- mem_rdy outside WBACK/FILL is ignored.

## Test plan
- Reset, then read 16'h0000 -> miss_cnt = 1; one fill at mem_addr 16'h0000; rdy on the re-LOOKUP; rdata = byte 0 of the supplied line; way 0 filled.
- Write 8'h5A to 16'h1203, then read 16'h1203 -> second access hits in 2 cycles, rdata = 8'h5A, hit_cnt = 1, line dirty.
- WAYS = 2, set 0 filled via tags 0 and 1 (one dirty), then access tag 2 -> victim = lfsr[0]. If the victim is dirty, a write-back at the old tag address precedes the fill.
- Fill all WAYS of one set -> ways fill in order 0, 1, ... with no LFSR use while an invalid way exists.
- Assert rst_n = 0 during FILL with mem_req high -> next cycle mem_req = 0, busy = 0, and a repeat access misses again.
- Preload miss_cnt near saturation (65537 misses, or force) -> miss_cnt holds at 16'hFFFF.
